// File: rtl/data_mem_arb_pkg.sv
// Shared defaults and requester identifiers for the data-memory arbiter.
package data_mem_arb_pkg;

    localparam int AW_DEFAULT = 6;
    localparam int DW_DEFAULT = 32;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: grants the sole eligible requester, or the one
// that did not win last time when both are eligible.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_grant_i,
    input  logic [1:0] block_i,
    output logic [1:0] gnt_o
);

    logic [1:0] eligible;

    always_comb begin
        gnt_o    = 2'b00;
        eligible = req_i & ~block_i;
        case (eligible)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (other_req(last_grant_i) == REQ0) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto one single-port data memory with registered read data.
// Define DATA_MEM_ARB_LOCK_EN to add lock_0/lock_1 ports for exclusive ownership.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          reset,
`ifdef DATA_MEM_ARB_LOCK_EN
    input  logic          lock_0,
    input  logic          lock_1,
`endif
    input  logic          req_0,
    input  logic          req_1,
    input  logic          we_0,
    input  logic          we_1,
    input  logic [AW-1:0] addr_0,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_0,
    input  logic [DW-1:0] wdata_1,
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata_0,
    output logic [DW-1:0] rdata_1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_MW,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_out
);

    req_id_t       last_grant_q, last_grant_d;
    logic [1:0]    req_vec;
    logic [1:0]    block_vec;
    logic [1:0]    gnt_vec;
    logic          any_gnt;
    req_id_t       winner;
    logic [1:0]    rvalid_q;
    logic [DW-1:0] rdata_0_q, rdata_1_q;

    // Masking requests with reset keeps grants and memory writes off while in reset.
    assign req_vec = {req_1, req_0} & {2{reset}};

`ifdef DATA_MEM_ARB_LOCK_EN
    logic       owner_vld_q, owner_vld_d;
    req_id_t    owner_q, owner_d;
    logic [1:0] lock_vec;
    logic       owner_holds;

    assign lock_vec    = {lock_1, lock_0};
    assign owner_holds = owner_vld_q & lock_vec[owner_q];
    assign block_vec   = owner_holds ? ((owner_q == REQ0) ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        if (owner_vld_q && !lock_vec[owner_q]) begin
            owner_vld_d = 1'b0;
        end
        if (any_gnt && lock_vec[winner]) begin
            owner_vld_d = 1'b1;
            owner_d     = winner;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            owner_vld_q <= 1'b0;
            owner_q     <= REQ0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
        end
    end
`else
    assign block_vec = 2'b00;
`endif

    rr_arb2 u_rr_arb2 (
        .req_i        (req_vec),
        .last_grant_i (last_grant_q),
        .block_i      (block_vec),
        .gnt_o        (gnt_vec)
    );

    assign gnt_0   = gnt_vec[0];
    assign gnt_1   = gnt_vec[1];
    assign any_gnt = |gnt_vec;
    assign winner  = gnt_vec[1] ? REQ1 : REQ0;

    always_comb begin
        mem_addr    = '0;
        mem_MW      = 1'b0;
        mem_data_in = '0;
        if (gnt_vec[0]) begin
            mem_addr    = addr_0;
            mem_MW      = we_0;
            mem_data_in = wdata_0;
        end else if (gnt_vec[1]) begin
            mem_addr    = addr_1;
            mem_MW      = we_1;
            mem_data_in = wdata_1;
        end
    end

    assign last_grant_d = any_gnt ? winner : last_grant_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            last_grant_q <= REQ1;
            rvalid_q     <= 2'b00;
            rdata_0_q    <= '0;
            rdata_1_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rvalid_q     <= {gnt_vec[1] & ~we_1, gnt_vec[0] & ~we_0};
            if (gnt_vec[0] && !we_0) begin
                rdata_0_q <= mem_out;
            end
            if (gnt_vec[1] && !we_1) begin
                rdata_1_q <= mem_out;
            end
        end
    end

    assign rvalid_0 = rvalid_q[0];
    assign rvalid_1 = rvalid_q[1];
    assign rdata_0  = rdata_0_q;
    assign rdata_1  = rdata_1_q;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
- REQ-001 Parameter AW, default 6, memory word-address width.
- REQ-002 Parameter DW, default 32, data width.
- REQ-003 CLK  input  1  single clock; all state updates on rising edge.
- REQ-004 reset  input  1  asynchronous, active-low reset.
- REQ-005 req_0 / req_1  input  1  access request from requester 0 / 1.
- REQ-006 we_0 / we_1  input  1  1 = write, 0 = read.
- REQ-007 addr_0 / addr_1  input  AW  word address.
- REQ-008 wdata_0 / wdata_1  input  DW  write data.
- REQ-009 gnt_0 / gnt_1  output  1  combinational grant; the access is performed this cycle.
- REQ-010 rvalid_0 / rvalid_1  output  1  read data valid, one cycle after a granted read.
- REQ-011 rdata_0 / rdata_1  output  DW  registered read data.
- REQ-012 mem_addr  output  AW  drives data_mem addr.
- REQ-013 mem_MW  output  1  drives data_mem MW.
- REQ-014 mem_data_in  output  DW  drives data_mem data_in.
- REQ-015 mem_out  input  DW  data_mem combinational read output for mem_addr.

Function
- REQ-016 At most one of gnt_0 and gnt_1 SHALL be high in any cycle, and only when the matching req is high.
- REQ-017 With a single requester active, the arbiter SHALL grant it in the same cycle, with no idle cycles between back-to-back requests.
- REQ-018 With both requesters active, the arbiter SHALL grant the requester that is not recorded in the last_grant register, giving strict alternation under continuous contention.
- REQ-019 last_grant SHALL update on every clock edge on which a grant occurs and SHALL hold otherwise.
- REQ-020 mem_addr, mem_MW and mem_data_in SHALL be driven combinationally from the winner's inputs, with mem_MW = winner's we.
- REQ-021 With no grant, the arbiter SHALL drive mem_MW = 0, mem_addr = 0 and mem_data_in = 0.
- REQ-022 A granted read SHALL capture mem_out into the winner's rdata register at the edge and assert that requester's rvalid for exactly one cycle.
- REQ-023 A granted write SHALL produce no rvalid; the write completes at the same edge.
- REQ-024 rdata SHALL hold its value until that requester's next granted read.
- REQ-025 A write followed on the next cycle by a read of the same address, by either requester, SHALL return the new data.
- REQ-026 A requester that is not granted SHALL keep its request pending, with no timeout.

Reset
- REQ-027 While reset = 0: gnt_x = 0, rvalid_x = 0, rdata_x = 0, mem_MW = 0, last_grant = 1 (requester 0 wins the first contention), lock owner cleared.
- REQ-028 Reset asserted mid-operation SHALL drop any pending rvalid, and no memory write SHALL occur while reset is low.

Configuration
- REQ-029 With macro DATA_MEM_ARB_LOCK_EN defined, the block SHALL have inputs lock_0 and lock_1 (1 bit each).
- REQ-030 Lock behaviour (macro defined): a granted requester asserting lock becomes owner. While the owner's lock stays high, the other requester SHALL NOT be granted. Ownership is released on the first cycle the owner's lock is low.
- REQ-031 Without the macro, the lock ports and the owner register SHALL be absent and arbitration SHALL be pure round-robin.

Structure
- REQ-032 Package data_mem_arb_pkg SHALL hold the AW and DW defaults and the requester-ID type (REQ0 = 0, REQ1 = 1).
- REQ-033 The round-robin selection SHALL live in sub-module rr_arb2 (inputs: two requests, last_grant, block mask; output: one-hot grant).

Verification
- REQ-034 req_0 write addr 1 data 0x56, then read addr 1 -> gnt_0 on both cycles; rvalid_0 the cycle after the read with rdata_0 = 0x56.
- REQ-035 req_0 and req_1 both reading for 4 cycles after reset -> grant order 0, 1, 0, 1; each rvalid follows its grant by 1 cycle.
- REQ-036 req_1 writes addr 2 data 0x25, while req_0 reads addr 2 on the next cycle -> rdata_0 = 0x25.
- REQ-037 Reset pulled low in the cycle after a granted read -> rvalid_0 never asserts; all outputs are 0 within the reset cycle.
- REQ-038 DATA_MEM_ARB_LOCK_EN: req_0 holds lock_0 high for 3 cycles while req_1 is active -> gnt_1 stays low for those cycles and gnt_1 asserts on the first cycle lock_0 is low.
- REQ-039 Idle (no req) -> mem_MW = 0; data_mem contents unchanged (read back addr 3 = previous value).
